// File: rtl/gpio_cond_pkg.sv
// Shared definitions for the GPIO input conditioner: per-bit debounce FSM
// state encoding and default synchroniser / debounce depths.
package gpio_cond_pkg;

   typedef enum logic [1:0] {
      LOW    = 2'b00,
      CNT_HI = 2'b01,
      HIGH   = 2'b11,
      CNT_LO = 2'b10
   } deb_state_t;

   localparam int unsigned SYNC_STAGES_DEF     = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchroniser, debounce FSM with a
// stability counter, and registered rise/fall pulses.
module debounce_bit
   import gpio_cond_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   deb_state_t             state, state_next;
   logic [CW-1:0]          cnt, cnt_next;
   logic                   rise_next, fall_next;

   assign s = sync[SYNC_STAGES-1];

   // Shift the raw input through the synchroniser chain.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sync <= '0;
      else          sync <= {sync[SYNC_STAGES-2:0], raw};
   end

   // FSM state, stability counter and pulse registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= LOW;
         cnt        <= '0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         rise_pulse <= rise_next;
         fall_pulse <= fall_next;
      end
   end

   // Next-state, counter update and pulse requests.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      case (state)
         LOW: begin
            if (s) begin
               state_next = CNT_HI;
               cnt_next   = CW'(1);
            end
         end
         CNT_HI: begin
            if (!s) begin
               state_next = LOW;
               cnt_next   = '0;
            end else if (cnt == TERM) begin
               state_next = HIGH;
               cnt_next   = '0;
               rise_next  = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         HIGH: begin
            if (!s) begin
               state_next = CNT_LO;
               cnt_next   = CW'(1);
            end
         end
         CNT_LO: begin
            if (s) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else if (cnt == TERM) begin
               state_next = LOW;
               cnt_next   = '0;
               fall_next  = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            state_next = LOW;
            cnt_next   = '0;
         end
      endcase
   end

   // The debounced level is 1 exactly in HIGH and CNT_LO (state bit 1).
   assign level = state[1];

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: WIDTH independent synchronise+debounce channels.
// Optional sticky latch on gpio_in, enabled by defining GPIO_IN_LATCH_EN.
module gpio_in_conditioner
   import gpio_cond_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_in,
   input  logic [WIDTH-1:0] latch_clr,
   output logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   logic [WIDTH-1:0] level;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clock      (clock),
         .reset_n    (reset_n),
         .raw        (raw_in[i]),
         .level      (level[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i])
      );
   end

`ifdef GPIO_IN_LATCH_EN
   logic [WIDTH-1:0] latch;
   logic [WIDTH-1:0] unused_level;

   assign unused_level = level;

   // Sticky latch: set by a rise pulse, cleared by latch_clr; set wins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) latch <= '0;
      else          latch <= (latch & ~latch_clr) | rise_pulse;
   end

   assign gpio_in = latch;
`else
   logic unused_latch_clr;

   assign unused_latch_clr = ^latch_clr;
   assign gpio_in          = level;
`endif

endmodule
